// File: rtl/cpu_run_ctrl_pkg.sv
// cpu_run_ctrl_pkg: shared state encoding and default widths for the run controller and its bench.
package cpu_run_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESET = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;
  localparam int DEF_PC_W  = 32;
  localparam int DEF_CNT_W = 16;
endpackage

// File: rtl/cpu_run_ctrl_if.sv
// cpu_run_ctrl_if: host/CPU-facing signals of the run controller (master = host side, slave = controller).
interface cpu_run_ctrl_if
  import cpu_run_ctrl_pkg::*;
#(
  parameter int PC_W  = DEF_PC_W,
  parameter int CNT_W = DEF_CNT_W
);
  logic             start;
  logic [PC_W-1:0]  pc_in;
  logic             retire_in;
  logic             cpu_rst_n;
  logic             cpu_en;
  logic             busy;
  logic             done;
  logic             halted;
  logic             timeout;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] retire_cnt;
  logic [CNT_W-1:0] stall_cnt;
  modport master (
    output start, pc_in, retire_in,
    input  cpu_rst_n, cpu_en, busy, done, halted, timeout, cycle_cnt, retire_cnt, stall_cnt
  );
  modport slave (
    input  start, pc_in, retire_in,
    output cpu_rst_n, cpu_en, busy, done, halted, timeout, cycle_cnt, retire_cnt, stall_cnt
  );
endinterface

// File: rtl/cpu_run_ctrl_sat_counter.sv
// cpu_run_ctrl_sat_counter: W-bit up counter with synchronous clear that sticks at all-ones.
module cpu_run_ctrl_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (clr) q <= '0;
    else if (inc && q != {W{1'b1}}) q <= q + 1'b1;
endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: CPU run controller with reset sequencing, cycle budget and PC-hold halt detection.
// Define STALL_COUNT_EN to build the stall counter; otherwise stall_cnt reads 0.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int PC_W        = DEF_PC_W,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int RST_HOLD    = 4,
  parameter int CYCLE_LIMIT = 45,
  parameter int HALT_STABLE = 3
) (
  input logic           clk,
  input logic           rst_n,
  cpu_run_ctrl_if.slave bus
);
  localparam int HW = $clog2(RST_HOLD + 1);
  localparam int SW = $clog2(HALT_STABLE + 1);
  state_t           state, state_nx;
  logic [PC_W-1:0]  pc_prev;
  logic [CNT_W-1:0] cycle_q, retire_q, stall_q;
  logic [HW-1:0]    hold_q;
  logic [SW-1:0]    stable_q;
  logic             run, first, pc_eq, go, hit_halt, hit_to, hold_end;
  logic             halted_q, timeout_q;
  assign run      = state == ST_RUN;
  assign first    = cycle_q == '0;
  assign pc_eq    = bus.pc_in == pc_prev;
  assign go       = bus.start && (state == ST_IDLE || state == ST_DONE);
  assign hold_end = state == ST_RESET && hold_q == HW'(RST_HOLD - 1);
  assign hit_halt = run && !first && pc_eq && stable_q == SW'(HALT_STABLE - 1);
  assign hit_to   = run && cycle_q == CNT_W'(CYCLE_LIMIT - 1);
  always_comb
    state_nx = go ? ST_RESET : hold_end ? ST_RUN : (hit_halt || hit_to) ? ST_DONE : state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else state <= state_nx;
  // first RUN cycle only captures; later cycles reload on any PC change
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pc_prev <= '0;
    else if (run && (first || !pc_eq)) pc_prev <= bus.pc_in;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      halted_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else if (go) begin
      halted_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else if (hit_halt || hit_to) begin
      halted_q  <= hit_halt;
      timeout_q <= !hit_halt;
    end
  cpu_run_ctrl_sat_counter #(.W(CNT_W)) u_cycle (
    .clk(clk), .rst_n(rst_n), .clr(go), .inc(run), .q(cycle_q)
  );
  cpu_run_ctrl_sat_counter #(.W(CNT_W)) u_retire (
    .clk(clk), .rst_n(rst_n), .clr(go), .inc(run && bus.retire_in), .q(retire_q)
  );
  cpu_run_ctrl_sat_counter #(.W(SW)) u_stable (
    .clk(clk), .rst_n(rst_n), .clr(go || (run && (first || !pc_eq))),
    .inc(run && !first && pc_eq), .q(stable_q)
  );
  cpu_run_ctrl_sat_counter #(.W(HW)) u_hold (
    .clk(clk), .rst_n(rst_n), .clr(go), .inc(state == ST_RESET), .q(hold_q)
  );
`ifdef STALL_COUNT_EN
  cpu_run_ctrl_sat_counter #(.W(CNT_W)) u_stall (
    .clk(clk), .rst_n(rst_n), .clr(go), .inc(run && !bus.retire_in), .q(stall_q)
  );
`else
  assign stall_q = '0;
`endif
  assign bus.cpu_rst_n  = state == ST_RUN || state == ST_DONE;
  assign bus.cpu_en     = run;
  assign bus.busy       = state == ST_RESET || state == ST_RUN;
  assign bus.done       = state == ST_DONE;
  assign bus.halted     = halted_q;
  assign bus.timeout    = timeout_q;
  assign bus.cycle_cnt  = cycle_q;
  assign bus.retire_cnt = retire_q;
  assign bus.stall_cnt  = stall_q;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: scoreboard bench for cpu_run_ctrl (default, CYCLE_LIMIT=10 and CNT_W=4 instances).
module tb_cpu_run_ctrl;
  import cpu_run_ctrl_pkg::*;
`ifdef STALL_COUNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif
  typedef struct {
    logic halted;
    logic timeout;
    int   cyc;
    int   ret;
    int   stall;
  } exp_t;
  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  cpu_run_ctrl_if #(.PC_W(DEF_PC_W), .CNT_W(DEF_CNT_W)) b0 ();
  cpu_run_ctrl_if #(.PC_W(DEF_PC_W), .CNT_W(DEF_CNT_W)) b1 ();
  cpu_run_ctrl_if #(.PC_W(DEF_PC_W), .CNT_W(4)) b2 ();
  cpu_run_ctrl #(.PC_W(DEF_PC_W), .CNT_W(DEF_CNT_W)) d0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  cpu_run_ctrl #(.PC_W(DEF_PC_W), .CNT_W(DEF_CNT_W), .CYCLE_LIMIT(10)) d1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  cpu_run_ctrl #(.PC_W(DEF_PC_W), .CNT_W(4), .CYCLE_LIMIT(15)) d2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  task automatic b0_pulse_start();
    b0.start = 1'b1;
    @(negedge clk);
    b0.start = 1'b0;
  endtask

  task automatic b0_wait_run(output int w);
    w = 0;
    while (!b0.cpu_en && w < 20) begin
      @(negedge clk);
      w++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_chk++;
    if ({b0.cpu_rst_n, b0.cpu_en, b0.busy, b0.done, b0.halted, b0.timeout} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 000000", {b0.cpu_rst_n, b0.cpu_en, b0.busy, b0.done, b0.halted, b0.timeout});
    end
    n_chk++;
    if ({b0.cycle_cnt, b0.retire_cnt, b0.stall_cnt, b2.cycle_cnt, b2.stall_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_counts got %h/%h/%h/%h/%h want 0", b0.cycle_cnt, b0.retire_cnt, b0.stall_cnt, b2.cycle_cnt, b2.stall_cnt);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({b0.busy, b0.done, b0.cpu_en, b0.cpu_rst_n, b1.busy, b2.busy} !== 6'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset got %b want 000000", {b0.busy, b0.done, b0.cpu_en, b0.cpu_rst_n, b1.busy, b2.busy});
    end
  endtask

  task automatic test_halt();
    exp_t e;
    int w, k;
    sb.push_back('{1'b1, 1'b0, 7, 4, STALL_EN ? 3 : 0});
    b0_pulse_start();
    n_chk++;
    if ({b0.busy, b0.cpu_rst_n, b0.cpu_en} !== 3'b100) begin
      n_fail++;
      $display("FAIL halt_launch busy/rst_n/en got %b want 100", {b0.busy, b0.cpu_rst_n, b0.cpu_en});
    end
    b0_wait_run(w);
    n_chk++;
    if (w != 4 || b0.cpu_rst_n !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_rst_hold cycles got %0d want 4 (cpu_rst_n=%b)", w, b0.cpu_rst_n);
    end
    k = 1;
    while (!b0.done && k < 100) begin
      b0.pc_in = k < 4 ? 32'(4 * (k - 1)) : 32'hC;
      b0.retire_in = k[0];
      @(negedge clk);
      k++;
    end
    b0.retire_in = 1'b0;
    n_chk++;
    if ({b0.done, b0.cpu_en, b0.busy} !== 3'b100 || k != 8) begin
      n_fail++;
      $display("FAIL halt_done done/en/busy got %b at run cycle %0d want 100 at 8", {b0.done, b0.cpu_en, b0.busy}, k);
    end
    e = sb.pop_front();
    n_chk++;
    if ({b0.halted, b0.timeout} !== {e.halted, e.timeout}) begin
      n_fail++;
      $display("FAIL halt_flags got %b%b want %b%b", b0.halted, b0.timeout, e.halted, e.timeout);
    end
    n_chk++;
    if (b0.cycle_cnt !== 16'(e.cyc) || b0.retire_cnt !== 16'(e.ret) || b0.stall_cnt !== 16'(e.stall)) begin
      n_fail++;
      $display("FAIL halt_counts got %0d/%0d/%0d want %0d/%0d/%0d", b0.cycle_cnt, b0.retire_cnt, b0.stall_cnt, e.cyc, e.ret, e.stall);
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    int w, k, ret;
    logic [63:0] pat;
    pat = {$urandom(), $urandom()};
    ret = $countones(pat[44:0]);
    sb.push_back('{1'b0, 1'b1, 45, ret, STALL_EN ? 45 - ret : 0});
    b0_pulse_start();
    b0_wait_run(w);
    k = 1;
    while (!b0.done && k < 100) begin
      b0.pc_in = 32'(4 * k);
      b0.retire_in = pat[k-1];
      @(negedge clk);
      k++;
    end
    b0.retire_in = 1'b0;
    e = sb.pop_front();
    n_chk++;
    if (!b0.done || {b0.halted, b0.timeout} !== {e.halted, e.timeout}) begin
      n_fail++;
      $display("FAIL timeout_flags done=%b got %b%b want %b%b", b0.done, b0.halted, b0.timeout, e.halted, e.timeout);
    end
    n_chk++;
    if (b0.cycle_cnt !== 16'(e.cyc) || b0.retire_cnt !== 16'(e.ret) || b0.stall_cnt !== 16'(e.stall)) begin
      n_fail++;
      $display("FAIL timeout_counts got %0d/%0d/%0d want %0d/%0d/%0d", b0.cycle_cnt, b0.retire_cnt, b0.stall_cnt, e.cyc, e.ret, e.stall);
    end
    b0.retire_in = 1'b1;
    b0.pc_in = 32'h40;
    repeat (3) @(negedge clk);
    b0.retire_in = 1'b0;
    n_chk++;
    if ({b0.done, b0.timeout, b0.cpu_en, b0.cpu_rst_n} !== 4'b1101 || b0.cycle_cnt !== 16'd45 || b0.retire_cnt !== 16'(ret)) begin
      n_fail++;
      $display("FAIL done_hold got flags %b cyc %0d ret %0d want 1101/45/%0d", {b0.done, b0.timeout, b0.cpu_en, b0.cpu_rst_n}, b0.cycle_cnt, b0.retire_cnt, ret);
    end
  endtask

  task automatic test_restart();
    exp_t e;
    int w, k;
    sb.push_back('{1'b1, 1'b0, 4, 4, 0});
    b0_pulse_start();
    n_chk++;
    if ({b0.done, b0.halted, b0.timeout, b0.cpu_rst_n, b0.busy} !== 5'b00001 || b0.cycle_cnt !== 16'd0 || b0.retire_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL restart_clear got flags %b cyc %0d ret %0d want 00001/0/0", {b0.done, b0.halted, b0.timeout, b0.cpu_rst_n, b0.busy}, b0.cycle_cnt, b0.retire_cnt);
    end
    b0_wait_run(w);
    n_chk++;
    if (w != 4) begin
      n_fail++;
      $display("FAIL restart_rst_hold cycles got %0d want 4", w);
    end
    k = 1;
    while (!b0.done && k < 100) begin
      b0.pc_in = 32'h100;
      b0.retire_in = 1'b1;
      b0.start = k == 3;
      @(negedge clk);
      k++;
    end
    b0.start = 1'b0;
    b0.retire_in = 1'b0;
    e = sb.pop_front();
    n_chk++;
    if (!b0.done || {b0.halted, b0.timeout} !== {e.halted, e.timeout}) begin
      n_fail++;
      $display("FAIL restart_flags done=%b got %b%b want %b%b", b0.done, b0.halted, b0.timeout, e.halted, e.timeout);
    end
    n_chk++;
    if (b0.cycle_cnt !== 16'(e.cyc) || b0.retire_cnt !== 16'(e.ret) || b0.stall_cnt !== 16'(e.stall)) begin
      n_fail++;
      $display("FAIL restart_counts got %0d/%0d/%0d want %0d/%0d/%0d", b0.cycle_cnt, b0.retire_cnt, b0.stall_cnt, e.cyc, e.ret, e.stall);
    end
  endtask

  task automatic test_reset_mid_run();
    int w;
    b0_pulse_start();
    b0_wait_run(w);
    for (int k = 1; k < 5; k++) begin
      b0.pc_in = 32'(4 * k);
      b0.retire_in = 1'b1;
      @(negedge clk);
    end
    n_chk++;
    if (b0.cpu_en !== 1'b1 || b0.cycle_cnt !== 16'd4 || b0.retire_cnt !== 16'd4) begin
      n_fail++;
      $display("FAIL midrun_before en=%b cyc %0d ret %0d want 1/4/4", b0.cpu_en, b0.cycle_cnt, b0.retire_cnt);
    end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({b0.cpu_en, b0.cpu_rst_n, b0.busy, b0.done, b0.halted, b0.timeout} !== 6'b0) begin
      n_fail++;
      $display("FAIL midrun_flags got %b want 000000", {b0.cpu_en, b0.cpu_rst_n, b0.busy, b0.done, b0.halted, b0.timeout});
    end
    n_chk++;
    if ({b0.cycle_cnt, b0.retire_cnt, b0.stall_cnt} !== '0) begin
      n_fail++;
      $display("FAIL midrun_counts got %0d/%0d/%0d want 0/0/0", b0.cycle_cnt, b0.retire_cnt, b0.stall_cnt);
    end
    b0.retire_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({b0.busy, b0.done, b0.cpu_en, b0.cpu_rst_n} !== 4'b0 || b0.cycle_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL midrun_idle got %b cyc %0d want 0000/0", {b0.busy, b0.done, b0.cpu_en, b0.cpu_rst_n}, b0.cycle_cnt);
    end
  endtask

  task automatic test_simultaneous();
    exp_t e;
    int w, k;
    sb.push_back('{1'b1, 1'b0, 10, 0, STALL_EN ? 10 : 0});
    b1.start = 1'b1;
    @(negedge clk);
    b1.start = 1'b0;
    w = 0;
    while (!b1.cpu_en && w < 20) begin
      @(negedge clk);
      w++;
    end
    k = 1;
    while (!b1.done && k < 100) begin
      b1.pc_in = k < 7 ? 32'(4 * k) : 32'h700;
      @(negedge clk);
      k++;
    end
    e = sb.pop_front();
    n_chk++;
    if (!b1.done || {b1.halted, b1.timeout} !== {e.halted, e.timeout}) begin
      n_fail++;
      $display("FAIL simul_flags done=%b got %b%b want %b%b", b1.done, b1.halted, b1.timeout, e.halted, e.timeout);
    end
    n_chk++;
    if (b1.cycle_cnt !== 16'(e.cyc) || b1.retire_cnt !== 16'(e.ret) || b1.stall_cnt !== 16'(e.stall)) begin
      n_fail++;
      $display("FAIL simul_counts got %0d/%0d/%0d want %0d/%0d/%0d", b1.cycle_cnt, b1.retire_cnt, b1.stall_cnt, e.cyc, e.ret, e.stall);
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    int w, k;
    sb.push_back('{1'b0, 1'b1, 15, 0, STALL_EN ? 15 : 0});
    b2.start = 1'b1;
    @(negedge clk);
    b2.start = 1'b0;
    w = 0;
    while (!b2.cpu_en && w < 20) begin
      @(negedge clk);
      w++;
    end
    k = 1;
    while (!b2.done && k < 100) begin
      b2.pc_in = 32'(4 * k);
      @(negedge clk);
      k++;
    end
    e = sb.pop_front();
    n_chk++;
    if (!b2.done || {b2.halted, b2.timeout} !== {e.halted, e.timeout}) begin
      n_fail++;
      $display("FAIL sat_flags done=%b got %b%b want %b%b", b2.done, b2.halted, b2.timeout, e.halted, e.timeout);
    end
    repeat (3) @(negedge clk);
    n_chk++;
    if (b2.cycle_cnt !== 4'(e.cyc) || b2.retire_cnt !== 4'(e.ret) || b2.stall_cnt !== 4'(e.stall)) begin
      n_fail++;
      $display("FAIL sat_counts got %0d/%0d/%0d want %0d/%0d/%0d", b2.cycle_cnt, b2.retire_cnt, b2.stall_cnt, e.cyc, e.ret, e.stall);
    end
  endtask

  initial begin
    {b0.start, b0.retire_in, b1.start, b1.retire_in, b2.start, b2.retire_in} = '0;
    b0.pc_in = '0;
    b1.pc_in = '0;
    b2.pc_in = '0;
    test_reset();
    test_halt();
    test_timeout();
    test_restart();
    test_reset_mid_run();
    test_simultaneous();
    test_saturation();
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d entries want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
